fwd_scoreboard: RTL and testbench

- Parametrised successor to the pipeline's combinational forwarding logic.
- Tracks in-flight register writes in an internal tag pipeline, one slot per post-issue stage (slot 0 = EX, 1 = MEM, 2 = WB at default depth).
- Forwards the youngest matching result to each of NUM_SRC source operands and generates the load-use stall.
- Sits beside the ID stage; fed by ID issue info and per-stage result buses from the datapath.

---
 rtl/fwd_scoreboard.sv | 113 +++++++++++
 tb/tb_fwd_scoreboard.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_scoreboard.sv
// Forwarding scoreboard: tracks in-flight register writes per post-issue stage, forwards the
// youngest matching result to each source operand and raises the load-use stall.
module fwd_scoreboard #(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned REG_IDX_W = 5,
  parameter int unsigned NUM_SRC   = 2,
  parameter int unsigned DEPTH     = 3,
  parameter int unsigned LOAD_RDY  = 1,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           adv_i,
  input  logic                           flush_i,
  input  logic                           iss_valid_i,
  input  logic                           iss_we_i,
  input  logic                           iss_load_i,
  input  logic [REG_IDX_W-1:0]           iss_rd_idx_i,
  input  logic [NUM_SRC*REG_IDX_W-1:0]   rs_idx_i,
  input  logic [NUM_SRC-1:0]             rs_en_i,
  input  logic [DEPTH*DATA_W-1:0]        stage_data_i,
  output logic [NUM_SRC-1:0]             fwd_sig_o,
  output logic [NUM_SRC*DATA_W-1:0]      fwd_data_o,
  output logic                           stall_o,
  output logic [CNT_W-1:0]               stall_cnt_o
);

  logic [DEPTH-1:0]                v_q, v_d;
  logic [DEPTH-1:0]                we_q, we_d;
  logic [DEPTH-1:0]                load_q, load_d;
  logic [DEPTH-1:0][REG_IDX_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;

  logic [DEPTH-1:0]     live;
  logic [DEPTH-1:0]     ready;
  logic [NUM_SRC-1:0]   hazard;
  logic [REG_IDX_W-1:0] src;
  logic                 matched;

  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    assign live[k]  = v_q[k] & we_q[k] & (rd_q[k] != '0);
    assign ready[k] = live[k] & (~load_q[k] | (k >= LOAD_RDY));
  end

  // Slot 0 is the youngest; the first live hit decides, even if it is not yet ready.
  always_comb begin
    fwd_sig_o  = '0;
    fwd_data_o = '0;
    hazard     = '0;
    src        = '0;
    matched    = 1'b0;
    for (int j = 0; j < NUM_SRC; j++) begin
      src     = rs_idx_i[j*REG_IDX_W +: REG_IDX_W];
      matched = 1'b0;
      if (rs_en_i[j] && (src != '0)) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (!matched && live[k] && (rd_q[k] == src)) begin
            matched = 1'b1;
            if (ready[k]) begin
              fwd_sig_o[j]                   = 1'b1;
              fwd_data_o[j*DATA_W +: DATA_W] = stage_data_i[k*DATA_W +: DATA_W];
            end else begin
              hazard[j] = 1'b1;
            end
          end
        end
      end
    end
  end

  assign stall_o     = iss_valid_i & (|hazard);
  assign stall_cnt_o = cnt_q;

  always_comb begin
    v_d    = v_q;
    we_d   = we_q;
    load_d = load_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    if (adv_i) begin
      for (int k = 1; k < DEPTH; k++) begin
        v_d[k]    = v_q[k-1];
        we_d[k]   = we_q[k-1];
        load_d[k] = load_q[k-1];
        rd_d[k]   = rd_q[k-1];
      end
      v_d[0]    = iss_valid_i & ~stall_o & ~flush_i;
      we_d[0]   = iss_we_i;
      load_d[0] = iss_load_i;
      rd_d[0]   = iss_rd_idx_i;
      if (stall_o && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q    <= '0;
      we_q   <= '0;
      load_q <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
    end else begin
      v_q    <= v_d;
      we_q   <= we_d;
      load_q <= load_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard: directed hazard scenarios with literal expectations, then random
// traffic checked every cycle against a slot-array model of the forwarding rules.
module tb_fwd_scoreboard;

  localparam int DW = 64;
  localparam int RW = 5;
  localparam int NS = 2;
  localparam int D  = 3;
  localparam int LR = 1;
  localparam int CW = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             adv, flush, iss_valid, iss_we, iss_load;
  logic [RW-1:0]    iss_rd;
  logic [NS*RW-1:0] rs_idx;
  logic [NS-1:0]    rs_en;
  logic [D*DW-1:0]  stage_data;
  logic [NS-1:0]    fwd_sig_o;
  logic [NS*DW-1:0] fwd_data_o;
  logic             stall_o;
  logic [CW-1:0]    stall_cnt_o;

  fwd_scoreboard #(
    .DATA_W(DW), .REG_IDX_W(RW), .NUM_SRC(NS), .DEPTH(D), .LOAD_RDY(LR), .CNT_W(CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .adv_i        (adv),
    .flush_i      (flush),
    .iss_valid_i  (iss_valid),
    .iss_we_i     (iss_we),
    .iss_load_i   (iss_load),
    .iss_rd_idx_i (iss_rd),
    .rs_idx_i     (rs_idx),
    .rs_en_i      (rs_en),
    .stage_data_i (stage_data),
    .fwd_sig_o    (fwd_sig_o),
    .fwd_data_o   (fwd_data_o),
    .stall_o      (stall_o),
    .stall_cnt_o  (stall_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          v;
    logic          we;
    logic          ld;
    logic [RW-1:0] rd;
  } slot_t;

  slot_t            m [D];
  logic [CW-1:0]    mcnt;
  logic [NS-1:0]    exp_sig;
  logic [NS*DW-1:0] exp_data;
  logic             exp_stall;
  int               nchk  = 0;
  int               nfail = 0;
  logic             chk_en = 1'b0;

  // Search the in-flight list youngest-first for each enabled, non-x0 source.
  function automatic void model_eval(output logic [NS-1:0] sig, output logic [NS*DW-1:0] dat,
                                     output logic stall);
    logic          haz;
    logic [RW-1:0] idx;
    haz = 1'b0;
    sig = '0;
    dat = '0;
    for (int j = 0; j < NS; j++) begin
      idx = rs_idx[j*RW +: RW];
      if (rs_en[j] && idx != 0) begin
        for (int k = 0; k < D; k++) begin
          if (m[k].v && m[k].we && m[k].rd != 0 && m[k].rd == idx) begin
            if (!m[k].ld || k >= LR) begin
              sig[j]          = 1'b1;
              dat[j*DW +: DW] = stage_data[k*DW +: DW];
            end else begin
              haz = 1'b1;
            end
            break;
          end
        end
      end
    end
    stall = iss_valid & haz;
  endfunction

  always_comb model_eval(exp_sig, exp_data, exp_stall);

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < D; k++) m[k] <= '0;
      mcnt <= '0;
    end else if (adv) begin
      if (exp_stall && mcnt != '1) mcnt <= mcnt + 1;
      for (int k = 1; k < D; k++) m[k] <= m[k-1];
      m[0] <= '{v: iss_valid & ~exp_stall & ~flush, we: iss_we, ld: iss_load, rd: iss_rd};
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model.fwd_sig", fwd_sig_o, exp_sig);
      chk("model.fwd_data", fwd_data_o, exp_data);
      chk("model.stall", stall_o, exp_stall);
      chk("model.stall_cnt", stall_cnt_o, mcnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    adv = 1'b1; flush = 1'b0; iss_valid = 1'b0; iss_we = 1'b0; iss_load = 1'b0;
    iss_rd = '0; rs_idx = '0; rs_en = '0; stage_data = '0;
  endtask

  task automatic issue(input logic we, input logic ld, input logic [RW-1:0] rd);
    idle();
    iss_valid = 1'b1; iss_we = we; iss_load = ld; iss_rd = rd;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst.fwd_sig", fwd_sig_o, 0);
    chk("rst.fwd_data", fwd_data_o, 0);
    chk("rst.stall", stall_o, 0);
    chk("rst.cnt", stall_cnt_o, 0);

    // ALU-to-ALU forward of x5
    tick(); issue(1, 0, 5);
    tick(); idle(); rs_idx[4:0] = 5; rs_en = 2'b01; stage_data[63:0] = 64'h1234;
    @(negedge clk);
    chk("alu.fwd_sig", fwd_sig_o, 2'b01);
    chk("alu.fwd_data", fwd_data_o[63:0], 64'h1234);
    chk("alu.stall", stall_o, 0);

    // Load-use on x7 via source 1
    tick(); issue(1, 1, 7);
    tick(); issue(0, 0, 0); rs_idx[9:5] = 7; rs_en = 2'b10;
    @(negedge clk);
    chk("lu.stall", stall_o, 1);
    chk("lu.fwd_sig", fwd_sig_o[1], 0);
    tick(); stage_data[127:64] = 64'hBEEF;
    @(negedge clk);
    chk("lu2.stall", stall_o, 0);
    chk("lu2.fwd_sig", fwd_sig_o, 2'b10);
    chk("lu2.fwd_data", fwd_data_o[127:64], 64'hBEEF);
    chk("lu2.cnt", stall_cnt_o, 1);

    // Youngest priority: x3 in slots 0 and 2
    tick(); issue(1, 0, 3);
    tick(); issue(0, 0, 0);
    tick(); issue(1, 0, 3);
    tick(); issue(1, 1, 3); rs_idx[4:0] = 3; rs_en = 2'b01;
    stage_data[63:0] = 64'hBB; stage_data[191:128] = 64'hAA;
    @(negedge clk);
    chk("young.fwd_sig", fwd_sig_o, 2'b01);
    chk("young.fwd_data", fwd_data_o[63:0], 64'hBB);
    // Slot 0 now holds a load of x3; older ready x3 must not win. Freeze too.
    tick(); issue(0, 0, 0); rs_idx[4:0] = 3; rs_en = 2'b01; adv = 1'b0;
    stage_data[63:0] = 64'hBB; stage_data[127:64] = 64'hAA;
    @(negedge clk);
    chk("yload.stall", stall_o, 1);
    chk("yload.fwd_sig", fwd_sig_o, 0);
    chk("yload.fwd_data", fwd_data_o, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      chk("frz.stall", stall_o, 1);
      chk("frz.cnt", stall_cnt_o, 1);
    end
    adv = 1'b1; stage_data[127:64] = 64'hCC;
    tick();
    @(negedge clk);
    chk("thaw.stall", stall_o, 0);
    chk("thaw.fwd_sig", fwd_sig_o, 2'b01);
    chk("thaw.fwd_data", fwd_data_o[63:0], 64'hCC);
    chk("thaw.cnt", stall_cnt_o, 2);

    // x0 never tracked; disabled source never forwards or stalls
    tick(); issue(1, 0, 0);
    tick(); issue(0, 0, 0); rs_en = 2'b01; stage_data[63:0] = 64'h55;
    @(negedge clk);
    chk("x0.fwd_sig", fwd_sig_o, 0);
    chk("x0.stall", stall_o, 0);
    tick(); issue(1, 1, 8);
    tick(); issue(0, 0, 0); rs_idx = {5'd8, 5'd8}; rs_en = 2'b00;
    @(negedge clk);
    chk("dis.fwd_sig", fwd_sig_o, 0);
    chk("dis.stall", stall_o, 0);

    // Flushed write of x9 leaves no trace
    tick(); issue(1, 0, 9); flush = 1'b1;
    tick(); issue(0, 0, 0); rs_idx[4:0] = 9; rs_en = 2'b01; stage_data[63:0] = 64'h99;
    @(negedge clk);
    chk("flush.fwd_sig", fwd_sig_o, 0);
    chk("flush.stall", stall_o, 0);

    // Reset mid-hazard
    tick(); issue(1, 1, 10);
    tick(); issue(0, 0, 0); rs_idx[4:0] = 10; rs_en = 2'b01;
    @(negedge clk);
    chk("prerst.stall", stall_o, 1);
    #1 rst = 1'b1;
    tick(); rst = 1'b0;
    @(negedge clk);
    chk("midrst.stall", stall_o, 0);
    chk("midrst.cnt", stall_cnt_o, 0);
    chk("midrst.fwd_sig", fwd_sig_o, 0);

    // Random traffic with a narrow register range to provoke hits
    for (int n = 0; n < 3000; n++) begin
      tick();
      rst       = ($urandom_range(63) == 0);
      adv       = ($urandom_range(9) < 8);
      flush     = ($urandom_range(9) == 0);
      iss_valid = ($urandom_range(9) < 7);
      iss_we    = ($urandom_range(9) < 8);
      iss_load  = ($urandom_range(9) < 3);
      iss_rd    = RW'($urandom_range(7));
      rs_idx    = {RW'($urandom_range(7)), RW'($urandom_range(7))};
      rs_en     = NS'($urandom_range(3));
      for (int i = 0; i < D * 2; i++) stage_data[i*32 +: 32] = $urandom;
    end
    tick();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
    $finish;
  end

endmodule
